ahb_slave_sram: RTL and testbench

AHB_SLAVE_SRAM -- requirements
Module: ahb_slave_sram

---
 rtl/ahb_slave_sram.sv | 132 +++++++++++++
 tb/tb_ahb_slave_sram.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_sram.sv
// rtl/ahb_slave_sram.sv - AHB-Lite word SRAM slave with programmable wait states and two-cycle ERROR response
module ahb_slave_sram #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic [31:0] hrdata_o,
  output logic        hreadyout_o,
  output logic        hresp_o
);

  localparam int AW = $clog2(DEPTH) + 2;
  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        xfer_err;
  logic        ready_c;
  logic        resp_c;
  logic [3:0]  byte_en;
  state_t      new_state;

  // Burst type and SEQ/NONSEQ distinction have no effect on this slave.
  logic unused_ok;
  assign unused_ok = ^{hburst_i, htrans_i[0]};

  // New address phases are only taken when no data phase is stalling the bus.
  assign accept = hsel_i && htrans_i[1] && hready_i &&
                  (state_q == ST_IDLE || state_q == ST_LAST || state_q == ST_ERR2);

  assign xfer_err = (haddr_i >= 32'(DEPTH * 4)) ||
                    (hsize_i > 3'd2) ||
                    (hsize_i == 3'd1 && haddr_i[0]) ||
                    (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00);

  assign new_state = xfer_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_c = 1'b1;
    resp_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = new_state;
      end
      ST_WAIT: begin
        ready_c = 1'b0;
        if (cnt_q == WS_LAST) begin
          state_d = ST_LAST;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_LAST: begin
        state_d = accept ? new_state : ST_IDLE;
      end
      ST_ERR1: begin
        ready_c = 1'b0;
        resp_c  = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        resp_c  = 1'b1;
        state_d = accept ? new_state : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << addr_q[1:0];
      2'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= haddr_i[AW-1:0];
        write_q <= hwrite_i;
        size_q  <= hsize_i[1:0];
      end
      if (state_q == ST_LAST && write_q) begin
        for (int b = 0; b < 4; b++)
          if (byte_en[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= hwdata_i[8*b +: 8];
      end
    end
  end

  // Outputs are forced to the idle response while reset is held, since state_q is only cleared at the edge.
  assign hreadyout_o = !rst_n || ready_c;
  assign hresp_o     = rst_n && resp_c;
  assign hrdata_o    = (rst_n && state_q == ST_LAST && !write_q) ? mem[addr_q[AW-1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// tb/tb_ahb_slave_sram.sv - randomized and directed checks of ahb_slave_sram against a transaction-level model
module tb_ahb_slave_sram;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_dut;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata1, hrdata_bus;
  logic        rdy0, rdy1, resp0, resp1, hready_bus, hresp_bus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign hready_bus = sel_dut ? rdy1 : rdy0;
  assign hresp_bus  = sel_dut ? resp1 : resp0;
  assign hrdata_bus = sel_dut ? rdata1 : rdata0;

  ahb_slave_sram #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel & ~sel_dut), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata), .hready_i(hready_bus),
    .hrdata_o(rdata0), .hreadyout_o(rdy0), .hresp_o(resp0)
  );

  ahb_slave_sram #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .hsel_i(hsel & sel_dut), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata), .hready_i(hready_bus),
    .hrdata_o(rdata1), .hreadyout_o(rdy1), .hresp_o(resp1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending data phase plus a word array; both DUTs share one model as only one is selected between resets.
  logic [31:0] mem [DEPTH];
  bit          dp_valid, dp_write, dp_err;
  int          dp_cyc;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;

  function automatic int cur_ws();
    return sel_dut ? 3 : 0;
  endfunction

  function automatic void model_outs(output logic r, output logic e, output logic [31:0] d);
    r = 1'b1; e = 1'b0; d = 32'h0;
    if (!rst_n || !dp_valid) return;
    if (dp_err) begin
      e = 1'b1;
      r = (dp_cyc >= 1);
    end else if (dp_cyc < cur_ws()) begin
      r = 1'b0;
    end else if (!dp_write) begin
      d = mem[dp_addr / 4];
    end
  endfunction

  always @(posedge clk) begin
    logic er, ee;
    logic [31:0] ed;
    int start, nb;
    model_outs(er, ee, ed);
    if (!rst_n) begin
      dp_valid = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    end else if (dp_valid && !er) begin
      dp_cyc++;
    end else begin
      if (dp_valid && !dp_err && dp_write) begin
        nb    = 1 << dp_size;
        start = (dp_size == 0) ? int'(dp_addr % 4) : (dp_size == 1) ? int'((dp_addr % 4) / 2) * 2 : 0;
        for (int b = 0; b < 4; b++)
          if (b >= start && b < start + nb) mem[dp_addr / 4][8*b +: 8] = hwdata[8*b +: 8];
      end
      if (hsel && htrans[1]) begin
        dp_valid = 1;
        dp_write = hwrite;
        dp_addr  = haddr;
        dp_size  = hsize;
        dp_cyc   = 0;
        dp_err   = (haddr >= DEPTH * 4) || (hsize > 2) ||
                   (hsize == 1 && haddr % 2 != 0) || (hsize == 2 && haddr % 4 != 0);
      end else begin
        dp_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic er, ee;
    logic [31:0] ed;
    model_outs(er, ee, ed);
    chk("cyc_hreadyout", {31'h0, hready_bus}, {31'h0, er});
    chk("cyc_hresp", {31'h0, hresp_bus}, {31'h0, ee});
    chk("cyc_hrdata", hrdata_bus, ed);
  end

  // Driver: inputs change 2 time units after the rising edge; ready is sampled at the falling edge.
  logic [31:0] cur_wdata = 32'h0;
  logic [31:0] last_rdata;
  logic        last_resp, last_wresp;
  int          last_waits;

  task automatic issue(input logic s, input logic [1:0] tr, input logic w, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    bit done = 0;
    int waits = 0;
    logic wresp = 1'b0;
    hsel = s; htrans = tr; hwrite = w; haddr = a; hsize = sz;
    hburst = 3'($urandom);
    hwdata = cur_wdata;
    for (int k = 0; k < 32 && !done; k++) begin
      @(negedge clk);
      if (hready_bus) begin
        done = 1;
        last_rdata = hrdata_bus;
        last_resp  = hresp_bus;
      end else begin
        waits++;
        wresp |= hresp_bus;
      end
      @(posedge clk); #2;
    end
    chk("ready_timeout", {31'h0, done}, 32'h1);
    last_waits = waits;
    last_wresp = wresp;
    cur_wdata  = wd;
  endtask

  task automatic idle();
    issue(1'b0, 2'd0, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  task automatic do_reset(input logic which);
    rst_n = 1'b0;
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd2; hburst = 3'd0; hwdata = 32'h0;
    sel_dut = which;
    repeat (2) begin @(posedge clk); #2; end
    rst_n = 1'b1;
    cur_wdata = 32'h0;
  endtask

  task automatic random_run(input int n);
    logic [2:0] sz;
    logic [31:0] a;
    int r;
    for (int i = 0; i < n; i++) begin
      r  = $urandom % 16;
      sz = (r < 5) ? 3'd0 : (r < 10) ? 3'd1 : (r < 15) ? 3'd2 : 3'd3;
      a  = $urandom % (DEPTH * 8);
      if ($urandom % 4 != 0) begin
        if (sz == 3'd1) a[0] = 1'b0;
        if (sz == 3'd2) a[1:0] = 2'b00;
      end
      issue(($urandom % 8) != 0, 2'($urandom), 1'($urandom), a, sz, $urandom);
    end
    idle();
    idle();
  endtask

  initial begin
    do_reset(1'b0);
    @(negedge clk);
    chk("reset_hreadyout", {31'h0, hready_bus}, 32'h1);
    chk("reset_hresp", {31'h0, hresp_bus}, 32'h0);
    chk("reset_hrdata", hrdata_bus, 32'h0);
    @(posedge clk); #2;

    issue(1'b1, 2'd2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 3'd2, 32'h0);
    idle();
    chk("word_rw_data", last_rdata, 32'hDEADBEEF);
    chk("word_rw_waits", last_waits, 0);
    chk("word_rw_resp", {31'h0, last_resp}, 32'h0);

    issue(1'b1, 2'd2, 1'b1, 32'h3, 3'd0, 32'hAA000000);
    issue(1'b1, 2'd2, 1'b1, 32'h0, 3'd1, 32'h00001234);
    issue(1'b1, 2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
    idle();
    chk("byte_half_merge", last_rdata, 32'hAA001234);

    issue(1'b1, 2'd2, 1'b1, 32'h4, 3'd2, 32'hC0FFEE11);
    issue(1'b1, 2'd3, 1'b0, 32'h4, 3'd2, 32'h0);
    idle();
    chk("b2b_raw_data", last_rdata, 32'hC0FFEE11);
    chk("b2b_raw_waits", last_waits, 0);

    issue(1'b1, 2'd2, 1'b1, 32'h100, 3'd2, 32'h12345678);
    idle();
    chk("err_wait_cycles", last_waits, 1);
    chk("err_first_resp", {31'h0, last_wresp}, 32'h1);
    chk("err_second_resp", {31'h0, last_resp}, 32'h1);
    issue(1'b1, 2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
    idle();
    chk("err_no_store", last_rdata, 32'hAA001234);

    random_run(300);

    do_reset(1'b1);
    @(posedge clk); #2;
    issue(1'b1, 2'd2, 1'b1, 32'h20, 3'd2, 32'h0BADF00D);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    idle();
    chk("ws3_read_waits", last_waits, 3);
    chk("ws3_read_data", last_rdata, 32'h0BADF00D);
    chk("ws3_read_resp", {31'h0, last_resp}, 32'h0);

    random_run(200);

    issue(1'b1, 2'd2, 1'b1, 32'h8, 3'd2, 32'h11112222);
    issue(1'b1, 2'd2, 1'b0, 32'h8, 3'd2, 32'h0);
    rst_n = 1'b0;
    hsel = 1'b0; htrans = 2'd0;
    @(negedge clk);
    chk("rst_in_wait_ready", {31'h0, hready_bus}, 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cur_wdata = 32'h0;
    @(negedge clk);
    chk("after_rst_ready", {31'h0, hready_bus}, 32'h1);
    @(posedge clk); #2;
    issue(1'b1, 2'd2, 1'b0, 32'h0, 3'd2, 32'h0);
    for (int i = 1; i <= DEPTH; i++) begin
      if (i < DEPTH) issue(1'b1, 2'd3, 1'b0, 32'(i * 4), 3'd2, 32'h0);
      else idle();
      chk($sformatf("rst_clear_w%0d", i - 1), last_rdata, 32'h0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
